// File: rtl/poly_unpack_if.sv
// Byte-stream and poly-RAM write bus for poly_unpack.
// master: upstream byte source plus RAM side; slave: the unpacker.
interface poly_unpack_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din;

  modport master (
    output din, din_valid,
    input  din_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/poly_unpack.sv
// NewHope 14-bit unpacker: 7 bytes -> 4 coefficients written to the poly RAM.
// POLY_UNPACK_REDUCE_EN: reduce c >= Q to c - Q (range_err tied low); else flag it in range_err.
module poly_unpack #(
  parameter int unsigned N_COEFF = 512,
  parameter int unsigned Q       = 12289
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         done,
  output logic         range_err,
  poly_unpack_if.slave bus
);

  localparam logic [8:0]  LastIdx = 9'(N_COEFF - 1);
  localparam logic [13:0] QVal    = 14'(Q);

  typedef enum logic [1:0] {StIdle, StRecv, StEmit} state_e;

  state_e      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [8:0]  coeff_cnt_q, coeff_cnt_d;
  logic [55:0] grp_q, grp_d;
  logic        ram_we_q, ram_we_d;
  logic [8:0]  ram_addr_q, ram_addr_d;
  logic [15:0] ram_din_q, ram_din_d;
  logic        done_q, done_d;
  logic        range_err_q, range_err_d;

  logic [13:0] coef_raw;
  logic [13:0] coef_out;
  logic        coef_ge;

  // Packing is little-endian and contiguous: coefficient k is bits [14k+13:14k].
  always_comb begin
    coef_raw = grp_q[13:0];
    unique case (coeff_cnt_q[1:0])
      2'd0:    coef_raw = grp_q[13:0];
      2'd1:    coef_raw = grp_q[27:14];
      2'd2:    coef_raw = grp_q[41:28];
      default: coef_raw = grp_q[55:42];
    endcase
  end

  assign coef_ge = (coef_raw >= QVal);

`ifdef POLY_UNPACK_REDUCE_EN
  assign coef_out = coef_ge ? (coef_raw - QVal) : coef_raw;
`else
  assign coef_out = coef_raw;
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    coeff_cnt_d = coeff_cnt_q;
    grp_d       = grp_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    range_err_d = range_err_q;
    // done follows the registered write of the last index by one cycle
    done_d      = ram_we_q && (ram_addr_q == LastIdx);

    case (state_q)
      StIdle: begin
        // A start coinciding with done is deliberately dropped.
        if (start && !done_q) begin
          state_d     = StRecv;
          byte_cnt_d  = 3'd0;
          coeff_cnt_d = 9'd0;
          range_err_d = 1'b0;
        end
      end
      StRecv: begin
        if (bus.din_valid) begin
          grp_d[{byte_cnt_q, 3'b000} +: 8] = bus.din;
          if (byte_cnt_q == 3'd6) begin
            byte_cnt_d = 3'd0;
            state_d    = StEmit;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StEmit: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = coeff_cnt_q;
        ram_din_d   = {2'b00, coef_out};
        coeff_cnt_d = coeff_cnt_q + 9'd1;
`ifndef POLY_UNPACK_REDUCE_EN
        if (coef_ge) begin
          range_err_d = 1'b1;
        end
`endif
        if (coeff_cnt_q[1:0] == 2'd3) begin
          state_d = (coeff_cnt_q == LastIdx) ? StIdle : StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= 3'd0;
      coeff_cnt_q <= 9'd0;
      grp_q       <= 56'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 9'd0;
      ram_din_q   <= 16'd0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      coeff_cnt_q <= coeff_cnt_d;
      grp_q       <= grp_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.din_ready = (state_q == StRecv);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign done          = done_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_poly_unpack.sv
// Scoreboard bench for poly_unpack: driver pushes expected writes, monitor pops and compares.
module tb_poly_unpack;

  localparam int Q = 12289;
`ifdef POLY_UNPACK_REDUCE_EN
  localparam bit Reduce = 1'b1;
`else
  localparam bit Reduce = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done;
  logic range_err;

  poly_unpack_if bus ();

  poly_unpack #(.N_COEFF(512), .Q(12289)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .range_err (range_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
    bit          bad;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   run_id = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int       run_seen = 0;
  int       ncap = 0;
  int       cap[4];
  bit       bad_prev = 1'b0;
  bit       prev_last = 1'b0;
  bit       got_first = 1'b0;
  int       first_recv = 0;
  int       last_wr = 0;
  int       done_cnt = 0;
  int       grp_bytes = 0;
  int       emit_chk = 0;
  exp_t     me;

  always @(negedge clk) begin
    if (!rst) begin
      grp_bytes = 0;
      emit_chk  = 0;
      bad_prev  = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (run_id != run_seen) begin
        run_seen  = run_id;
        bad_prev  = 1'b0;
        ncap      = 0;
        got_first = 1'b0;
      end
      if (bus.din_ready && !got_first) begin
        got_first  = 1'b1;
        first_recv = cyc;
      end
      // the four cycles after a group's 7th byte are EMIT
      if (emit_chk > 0) begin
        check("din_ready_in_emit", int'(bus.din_ready), 0);
        emit_chk--;
      end else if (bus.din_valid && bus.din_ready) begin
        grp_bytes++;
        if (grp_bytes == 7) begin
          grp_bytes = 0;
          emit_chk  = 4;
        end
      end
      if (done || prev_last) begin
        check("done_pulse", int'(done), int'(prev_last));
        if (done) begin
          check("ram_we_in_done", int'(bus.ram_we), 0);
          done_cnt++;
        end
      end
      prev_last = bus.ram_we && (bus.ram_addr == 9'd511);
      if (bus.ram_we) begin
        if (bus.ram_addr == 9'd511) last_wr = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                   bus.ram_addr, bus.ram_din);
        end else begin
          me = sb.pop_front();
          check("wr_addr", int'(bus.ram_addr), int'(me.addr));
          check("wr_data", int'(bus.ram_din), int'(me.data));
          if (Reduce) check("range_err_tied", int'(range_err), 0);
          else if (bad_prev) check("range_err_sticky", int'(range_err), 1);
          else if (!me.bad) check("range_err_clear", int'(range_err), 0);
          if (me.bad) bad_prev = 1'b1;
          if (ncap < 4) begin
            cap[ncap] = int'(bus.ram_din);
            ncap++;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic summary_fatal(input string why);
    fails++;
    $display("FAIL %s: got timeout, expected progress", why);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench aborted");
  endtask

  function automatic int byte_of(input int mode, input int idx);
    case (mode)
      0:       return idx % 7;
      1:       return 8'hFF;
      default: return (idx == 0) ? 8'h01 : ((idx == 1) ? 8'h30 : 0);
    endcase
  endfunction

  function automatic int model(input int b[7], input int k);
    case (k)
      0:       return b[0] | ((b[1] & 'h3F) << 8);
      1:       return (b[1] >> 6) | (b[2] << 2) | ((b[3] & 'h0F) << 10);
      2:       return (b[3] >> 4) | (b[4] << 4) | ((b[5] & 'h03) << 12);
      default: return (b[5] >> 2) | (b[6] << 6);
    endcase
  endfunction

  task automatic send_byte(input int v, input bit gaps);
    int n;
    if (gaps && ($urandom_range(1) == 1)) begin
      bus.din_valid = 1'b0;
      repeat ($urandom_range(3, 1)) tick();
    end
    bus.din       = 8'(v);
    bus.din_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.din_ready && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!bus.din_ready) summary_fatal("send_timeout");
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    run_id++;
    tick();
    start = 1'b0;
  endtask

  task automatic run_poly(input int mode, input bit gaps, input int limit);
    int   b[7];
    int   c;
    exp_t e;
    for (int g = 0; g < 128; g++) begin
      for (int i = 0; i < 7; i++) b[i] = byte_of(mode, g * 7 + i);
      for (int k = 0; k < 4; k++) begin
        c      = model(b, k);
        e.addr = 9'(g * 4 + k);
        e.bad  = (c >= Q);
        e.data = 16'((e.bad && Reduce) ? c - Q : c);
        sb.push_back(e);
      end
      for (int i = 0; i < 7; i++) begin
        if (g * 7 + i == limit) return;
        send_byte(b[i], gaps);
      end
    end
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
    repeat (2) tick();
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din_ready"}, int'(bus.din_ready), 0);
    check({tag, "_ram_we"}, int'(bus.ram_we), 0);
    check({tag, "_ram_addr"}, int'(bus.ram_addr), 0);
    check({tag, "_ram_din"}, int'(bus.ram_din), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_range_err"}, int'(range_err), 0);
  endtask

  initial begin
    #2_000_000;
    summary_fatal("global_watchdog");
  end

  initial begin
    int d0;
    int n;
    bus.din       = 8'd0;
    bus.din_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();

    // pattern stream 0..6, no gaps: group 0 values and full-poly timing
    do_start();
    d0 = done_cnt;
    run_poly(0, 1'b0, -1);
    wait_done(d0);
    check("g0_c0", cap[0], 'h0100);
    check("g0_c1", cap[1], 'h0C08);
    check("g0_c2", cap[2], 'h1040);
    check("g0_c3", cap[3], 'h0181);
    check("last_write_latency", last_wr - first_recv, 1408);
    check("range_err_pattern", int'(range_err), 0);

    // all 0xFF
    do_start();
    d0 = done_cnt;
    run_poly(1, 1'b0, -1);
    wait_done(d0);
    check("ff_c0", cap[0], Reduce ? 4094 : 16383);
    check("ff_range_err", int'(range_err), Reduce ? 0 : 1);

    // valid gaps
    do_start();
    d0 = done_cnt;
    run_poly(0, 1'b1, -1);
    wait_done(d0);
    check("gap_c1", cap[1], 'h0C08);

    // reset after 300 bytes, then a clean run
    do_start();
    run_poly(0, 1'b0, 300);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) tick();
    @(negedge clk);
    check("midrst_idle", int'(bus.din_ready), 0);
    tick();
    do_start();
    d0 = done_cnt;
    run_poly(0, 1'b0, -1);
    wait_done(d0);
    check("midrst_c3", cap[3], 'h0181);

    // start pulses while busy and in the done cycle
    do_start();
    d0 = done_cnt;
    fork
      run_poly(0, 1'b0, -1);
      begin
        repeat (40) tick();
        start = 1'b1;
        repeat (15) tick();
        start = 1'b0;
      end
    join
    n = 0;
    @(negedge clk);
    while (!(bus.ram_we && bus.ram_addr == 9'd511) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("last_write_seen", int'(bus.ram_we && bus.ram_addr == 9'd511), 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("one_done_per_start", done_cnt - d0, 1);
    @(negedge clk);
    check("no_restart", int'(bus.din_ready), 0);
    check("busy_sb_drained", sb.size(), 0);
    tick();

    // coefficient exactly Q at address 0
    do_start();
    d0 = done_cnt;
    run_poly(2, 1'b0, -1);
    wait_done(d0);
    check("q_c0", cap[0], Reduce ? 0 : 12289);
    check("q_range_err", int'(range_err), Reduce ? 0 : 1);
    do_start();
    @(negedge clk);
    check("range_err_cleared_by_start", int'(range_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
